// File: rtl/bakery_pkg.sv
// rtl/bakery_pkg.sv - shared types and helpers for the bakery mutex model
//  loc        : program-counter locations of one bakery process
//  is_waiting : true for the doorway-to-entry wait locations L4..L8
package bakery_pkg;

  typedef enum logic [3:0] {
    L1, L2a, L2b, L2c, L3, L4, L5, L6, L7, L8, L9, L10a, L10b, L10c, L11
  } loc;

  function automatic logic is_waiting(loc l);
    return (l inside {L4, L5, L6, L7, L8});
  endfunction

endpackage

// File: rtl/bakery_starve_ctr.sv
// rtl/bakery_starve_ctr.sv - saturating starvation counter for one process
//  Built only when BAKERY_STARVE_MON_EN is defined.
//  clock, reset_n : clock and asynchronous active-low reset
//  clr            : process is outside the waiting set, count restarts
//  inc            : process was selected while waiting
//  full           : counter is all-ones
`ifdef BAKERY_STARVE_MON_EN
module bakery_starve_ctr #(
  parameter int W = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic full
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + W'(1);
    end
  end

  assign full = &count;

endmodule
`endif

// File: rtl/bakery_mutex_n.sv
// rtl/bakery_mutex_n.sv - NPROC-process bakery mutual-exclusion model, one step per cycle
//  Optional feature macro: BAKERY_STARVE_MON_EN (per-process starvation counters).
//  clock     : single clock, all state changes on posedge
//  reset_n   : asynchronous active-low reset
//  select    : process to step this cycle, values >= NPROC are idle cycles
//  pause     : stall at L9 (critical section) and L11 (noncritical section)
//  sel_reg   : latched selection, NPROC after an idle cycle
//  in_cs     : bit i set while process i is at L9
//  waiting   : bit i set while process i is in L4..L8
//  mutex_err : sticky, more than one in_cs bit was ever set
//  starve    : starvation flags, tied 0 without the macro
module bakery_mutex_n
  import bakery_pkg::*;
#(
  parameter int NPROC    = 3,
  parameter int SELW     = $clog2(NPROC + 1),
  parameter int STARVE_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [SELW-1:0]  select,
  input  logic             pause,
  output logic [SELW-1:0]  sel_reg,
  output logic [NPROC-1:0] in_cs,
  output logic [NPROC-1:0] waiting,
  output logic             mutex_err,
  output logic [NPROC-1:0] starve
);

  localparam logic [SELW-1:0] NPROC_S = SELW'(NPROC);

  loc                         pc   [NPROC];
  loc                         pc_n [NPROC];
  logic [SELW-1:0]            j    [NPROC];
  logic [SELW-1:0]            j_n  [NPROC];
  logic [NPROC-1:0]           ticket, ticket_n;
  logic [NPROC-1:0]           choosing, choosing_n;
  // defer[a][b]: b already held a ticket when a chose, so a is younger than b.
  logic [NPROC-1:0][NPROC-1:0] defer, defer_n;

  logic             step;
  logic [SELW-1:0]  s;
  logic [SELW-1:0]  k;
  logic [SELW-1:0]  k_inc;
  logic [NPROC-1:0] in_cs_n;
  logic [NPROC-1:0] waiting_n;
  logic             multi;

  assign step  = (select < NPROC_S);
  assign s     = select;
  assign k     = step ? j[s] : '0;
  // j saturates at NPROC so the loop exit test never sees a wrapped index.
  assign k_inc = (k == NPROC_S) ? k : k + SELW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPROC; i++) begin
        pc[i] <= L1;
        j[i]  <= '0;
      end
      ticket    <= '0;
      choosing  <= '0;
      defer     <= '0;
      sel_reg   <= NPROC_S;
      in_cs     <= '0;
      waiting   <= '0;
      mutex_err <= 1'b0;
    end else begin
      for (int i = 0; i < NPROC; i++) begin
        pc[i] <= pc_n[i];
        j[i]  <= j_n[i];
      end
      ticket    <= ticket_n;
      choosing  <= choosing_n;
      defer     <= defer_n;
      sel_reg   <= step ? select : NPROC_S;
      in_cs     <= in_cs_n;
      waiting   <= waiting_n;
      mutex_err <= mutex_err | multi;
    end
  end

  always_comb begin
    for (int i = 0; i < NPROC; i++) begin
      pc_n[i] = pc[i];
      j_n[i]  = j[i];
    end
    ticket_n   = ticket;
    choosing_n = choosing;
    defer_n    = defer;
    if (step) begin
      case (pc[s])
        L1:   begin choosing_n[s] = 1'b1; pc_n[s] = L2a; end
        L2a:  begin j_n[s] = '0; pc_n[s] = L2b; end
        L2b:  pc_n[s] = (k < NPROC_S) ? L2c : L3;
        L2c:  begin defer_n[s][k] = ticket[k]; j_n[s] = k_inc; pc_n[s] = L2b; end
        L3:   begin ticket_n[s] = 1'b1; choosing_n[s] = 1'b0; pc_n[s] = L4; end
        L4:   begin j_n[s] = '0; pc_n[s] = L5; end
        L5:   pc_n[s] = (k < NPROC_S) ? L6 : L9;
        L6:   pc_n[s] = choosing[k] ? L6 : L7;
        // Older ticket wins; with no defer either way the lower index wins.
        L7:   pc_n[s] = (ticket[k] && (defer[s][k] || (!defer[k][s] && (k < s)))) ? L7 : L8;
        L8:   begin j_n[s] = k_inc; pc_n[s] = L5; end
        L9:   pc_n[s] = pause ? L9 : L10a;
        L10a: begin ticket_n[s] = 1'b0; j_n[s] = '0; pc_n[s] = L10b; end
        L10b: pc_n[s] = (k < NPROC_S) ? L10c : L11;
        L10c: begin defer_n[k][s] = 1'b0; j_n[s] = k_inc; pc_n[s] = L10b; end
        L11:  pc_n[s] = pause ? L11 : L1;
        default: pc_n[s] = L1;
      endcase
    end
  end

  always_comb begin
    in_cs_n   = '0;
    waiting_n = '0;
    for (int i = 0; i < NPROC; i++) begin
      in_cs_n[i]   = (pc_n[i] == L9);
      waiting_n[i] = is_waiting(pc_n[i]);
    end
    multi = |(in_cs_n & (in_cs_n - NPROC'(1)));
  end

`ifdef BAKERY_STARVE_MON_EN
  for (genvar gi = 0; gi < NPROC; gi++) begin : g_starve
    logic inc;
    assign inc = step && (s == SELW'(gi)) && is_waiting(pc[gi]);
    bakery_starve_ctr #(.W(STARVE_W)) u_ctr (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (!waiting_n[gi]),
      .inc     (inc),
      .full    (starve[gi])
    );
  end
`else
  logic unused_starve_w;
  assign unused_starve_w = (STARVE_W != 0);
  assign starve = '0;
`endif

endmodule
